// File: rtl/enc_74ls148_latched_pkg.sv
// Shared types and helpers for the latched 74LS148-style priority encoder.
package enc148_pkg;

  typedef enum logic {IDLE, PRESENT} enc_state_t;

  localparam int unsigned NREQ = 8;
  localparam int unsigned IDXW = 3;

  // Highest set bit wins; returns 0 for an empty vector.
  function automatic logic [IDXW-1:0] prio_idx(input logic [NREQ-1:0] req);
    logic [IDXW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req[i]) r = IDXW'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/enc_74ls148_latched_if.sv
// Request/code handshake bundle in 74LS148 pin style (active-low lines and flags).
interface enc_74ls148_latched_if;
  import enc148_pkg::*;

  logic [NREQ-1:0] I_n;
  logic            EI_n;
  logic            ack;
  logic [IDXW-1:0] A_n;
  logic            valid;
  logic            GS_n;
  logic            EO_n;

  modport master (
    output I_n, EI_n, ack,
    input  A_n, valid, GS_n, EO_n
  );

  modport slave (
    input  I_n, EI_n, ack,
    output A_n, valid, GS_n, EO_n
  );
endinterface

// File: rtl/enc_74ls148_latched_prio_enc8.sv
// Combinational 8-to-3 priority encoder over the pending request set.
module prio_enc8
  import enc148_pkg::*;
(
  input  logic [NREQ-1:0] pending,
  output logic [IDXW-1:0] idx,
  output logic            any
);

  always_comb begin
    idx = prio_idx(pending);
    any = |pending;
  end

endmodule

// File: rtl/enc_74ls148_latched.sv
// Registered priority encoder: latches active-low requests, presents the highest
// pending index with a valid/ack handshake and clears it once served.
module enc_74ls148_latched
  import enc148_pkg::*;
#(
  parameter bit STICKY = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  enc_74ls148_latched_if.slave    bus
);

  enc_state_t      state, state_nxt;
  logic [NREQ-1:0] pending, pending_nxt, clr, req_in;
  logic [IDXW-1:0] idx;
  logic            any;
  logic [IDXW-1:0] a_n_q, a_n_nxt;
  logic            valid_q, valid_nxt;
  logic            eo_n_q, eo_n_nxt;

  prio_enc8 u_prio (
    .pending (pending),
    .idx     (idx),
    .any     (any)
  );

  always_comb begin
    req_in      = bus.EI_n ? '0 : ~bus.I_n;
    clr         = '0;
    state_nxt   = state;
    a_n_nxt     = a_n_q;
    valid_nxt   = valid_q;
    unique case (state)
      IDLE: begin
        if (any) begin
          state_nxt = PRESENT;
          a_n_nxt   = ~idx;
          valid_nxt = 1'b1;
        end
      end
      PRESENT: begin
        // The served index is recovered from the held code, so a newly
        // arriving higher request cannot redirect the clear.
        if (bus.ack) begin
          state_nxt   = IDLE;
          a_n_nxt     = '1;
          valid_nxt   = 1'b0;
          clr[~a_n_q] = 1'b1;
        end
      end
    endcase
    // Set is OR-ed after the clear so a re-asserted request survives its own ack.
    pending_nxt = STICKY ? ((pending & ~clr) | req_in) : req_in;
    eo_n_nxt    = ~(~bus.EI_n && !any && (state == IDLE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
      a_n_q   <= '1;
      valid_q <= 1'b0;
      eo_n_q  <= 1'b1;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      a_n_q   <= a_n_nxt;
      valid_q <= valid_nxt;
      eo_n_q  <= eo_n_nxt;
    end
  end

  assign bus.A_n   = a_n_q;
  assign bus.valid = valid_q;
  assign bus.GS_n  = ~valid_q;
  assign bus.EO_n  = eo_n_q;

endmodule

// File: tb/tb_enc_74ls148_latched.sv
// Directed, table-driven bench for the latched 74LS148-style encoder.
module tb_enc_74ls148_latched;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  enc_74ls148_latched_if bus ();

  enc_74ls148_latched #(.STICKY(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       rst;
    logic [7:0] i_n;
    logic       ei_n;
    logic       ack;
    logic [2:0] a_n;
    logic       valid;
    logic       eo_n;
    logic [7:0] pend;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [7:0] i, input logic ei, input logic ak,
                     input logic [2:0] a, input logic v, input logic eo, input logic [7:0] p);
    vec_t t;
    t.rst = r; t.i_n = i; t.ei_n = ei; t.ack = ak;
    t.a_n = a; t.valid = v; t.eo_n = eo; t.pend = p;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic [7:0] i, input logic ei, input logic ak);
    rst = r; bus.I_n = i; bus.EI_n = ei; bus.ack = ak;
  endtask

  task automatic check_outs(input string tag, input logic [2:0] a, input logic v,
                            input logic eo, input logic [7:0] p);
    chk({tag, ".A_n"},   {5'd0, bus.A_n}, {5'd0, a});
    chk({tag, ".valid"}, {7'd0, bus.valid}, {7'd0, v});
    chk({tag, ".GS_n"},  {7'd0, bus.GS_n}, {7'd0, ~v});
    chk({tag, ".EO_n"},  {7'd0, bus.EO_n}, {7'd0, eo});
    chk({tag, ".pend"},  dut.pending, p);
  endtask

  initial begin
    drive(1'b1, 8'h00, 1'b0, 1'b0);

    //   rst  I_n    EI ack  A_n     v     EO    pending
    // reset
    add(1, 8'h00, 0, 0, 3'b111, 0, 1, 8'h00);
    add(1, 8'h00, 0, 0, 3'b111, 0, 1, 8'h00);
    add(0, 8'hFF, 0, 0, 3'b111, 0, 0, 8'h00);
    // single request idx 2
    add(0, 8'hFB, 0, 0, 3'b111, 0, 0, 8'h04);
    add(0, 8'hFF, 0, 0, 3'b101, 1, 1, 8'h04);
    add(0, 8'hFF, 0, 1, 3'b111, 0, 1, 8'h00);
    add(0, 8'hFF, 0, 0, 3'b111, 0, 0, 8'h00);
    // queue 7,5,0
    add(0, 8'h5E, 0, 0, 3'b111, 0, 0, 8'hA1);
    add(0, 8'hFF, 0, 0, 3'b000, 1, 1, 8'hA1);
    add(0, 8'hFF, 0, 1, 3'b111, 0, 1, 8'h21);
    add(0, 8'hFF, 0, 0, 3'b010, 1, 1, 8'h21);
    add(0, 8'hFF, 0, 1, 3'b111, 0, 1, 8'h01);
    add(0, 8'hFF, 0, 0, 3'b111, 1, 1, 8'h01);
    add(0, 8'hFF, 0, 1, 3'b111, 0, 1, 8'h00);
    add(0, 8'hFF, 0, 0, 3'b111, 0, 0, 8'h00);
    // set wins over clear on idx 3
    add(0, 8'hF7, 0, 0, 3'b111, 0, 0, 8'h08);
    add(0, 8'hF7, 0, 0, 3'b100, 1, 1, 8'h08);
    add(0, 8'hF7, 0, 1, 3'b111, 0, 1, 8'h08);
    add(0, 8'hFF, 0, 0, 3'b100, 1, 1, 8'h08);
    add(0, 8'hFF, 0, 1, 3'b111, 0, 1, 8'h00);
    add(0, 8'hFF, 0, 0, 3'b111, 0, 0, 8'h00);
    // enable gate, stray ack while idle
    add(0, 8'h00, 1, 0, 3'b111, 0, 1, 8'h00);
    add(0, 8'h00, 1, 1, 3'b111, 0, 1, 8'h00);
    add(0, 8'h7F, 0, 0, 3'b111, 0, 0, 8'h80);
    add(0, 8'hFF, 0, 0, 3'b000, 1, 1, 8'h80);
    add(0, 8'h00, 1, 0, 3'b000, 1, 1, 8'h80);
    add(0, 8'h00, 1, 1, 3'b111, 0, 1, 8'h00);
    // mid-handshake reset with ack asserted
    add(0, 8'h7E, 0, 0, 3'b111, 0, 0, 8'h81);
    add(0, 8'hFF, 0, 0, 3'b000, 1, 1, 8'h81);
    add(1, 8'hFF, 0, 1, 3'b111, 0, 1, 8'h00);
    add(0, 8'hFF, 0, 0, 3'b111, 0, 0, 8'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].i_n, vecs[i].ei_n, vecs[i].ack);
      tick();
      check_outs($sformatf("v%0d", i), vecs[i].a_n, vecs[i].valid, vecs[i].eo_n, vecs[i].pend);
    end

    // Code stays stable while a higher request arrives, which is then served next.
    drive(1'b0, 8'hEF, 1'b0, 1'b0);
    tick();
    drive(1'b0, 8'hFF, 1'b0, 1'b0);
    begin
      int n;
      n = 0;
      while (!bus.valid && n < 6) begin
        tick();
        n++;
      end
      chk("wait_valid_idx4", {7'd0, bus.valid}, 8'h01);
    end
    chk("idx4.A_n", {5'd0, bus.A_n}, 8'h03);
    drive(1'b0, 8'h7F, 1'b0, 1'b0);
    tick();
    chk("hold.A_n", {5'd0, bus.A_n}, 8'h03);
    chk("hold.pend", dut.pending, 8'h90);
    drive(1'b0, 8'hFF, 1'b0, 1'b1);
    tick();
    chk("ack4.valid", {7'd0, bus.valid}, 8'h00);
    drive(1'b0, 8'hFF, 1'b0, 1'b0);
    tick();
    chk("next7.A_n", {5'd0, bus.A_n}, 8'h00);
    chk("next7.valid", {7'd0, bus.valid}, 8'h01);
    drive(1'b0, 8'hFF, 1'b0, 1'b1);
    tick();
    drive(1'b0, 8'hFF, 1'b0, 1'b0);
    tick();
    chk("drain.pend", dut.pending, 8'h00);
    chk("drain.EO_n", {7'd0, bus.EO_n}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
